// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//   Shares one combinational alu between two valid/ready requesters.
//   A round-robin grant picks one request per cycle. The ALU outputs and the
//   winner's id are captured in a single-entry response register, which has
//   valid/ready backpressure.
//
// Ports
//   clk, rst               : rising-edge clock, synchronous active-high reset
//   reqN_valid/reqN_ready  : request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op: operands and opcode for requester N
//   rsp_valid/rsp_ready    : response handshake
//   rsp_id                 : requester that issued the held response
//   rsp_result, rsp_carry,
//   rsp_overflow, rsp_zero : registered ALU outputs
//   gnt_cnt0, gnt_cnt1     : saturating accept counters (ALU_ARB_STATS_EN only)
//
// Build option
//   ALU_ARB_STATS_EN : adds the gnt_cnt0/gnt_cnt1 outputs and their counters.
//
// ALU opcode encoding (alu module)
//   0000 ADD   carry = bit WIDTH of the sum, overflow = signed overflow
//   0001 SUB   carry = borrow,              overflow = signed overflow
//   0010 AND   0011 OR   0100 XOR
//   0101 SHL by 1   0110 SHR by 1 (logical)
//   0111 CMP   result = {'0, a > b} (unsigned)
//   other      result = 0
//   zero = (result == 0) for every opcode
// -----------------------------------------------------------------------------
module alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    unique case (op)
      4'b0000: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        result   = diff[WIDTH-1:0];
        carry    = diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: result = a & b;
      4'b0011: result = a | b;
      4'b0100: result = a ^ b;
      4'b0101: result = {a[WIDTH-2:0], 1'b0};
      4'b0110: result = {1'b0, a[WIDTH-1:1]};
      4'b0111: result[0] = (a > b);
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

module alu_rr_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic             rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic             slot_free;
  logic             gnt_valid;
  logic             gnt_id;
  logic             accept;

  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry, alu_overflow, alu_zero;

  // Grant and datapath mux. With both requesters valid the one that did not
  // win last time goes, which gives strict alternation under full load.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    slot_free = (state_q == EMPTY) || rsp_ready;
    accept    = slot_free && gnt_valid && !rst;
    alu_a     = gnt_id ? req1_a  : req0_a;
    alu_b     = gnt_id ? req1_b  : req0_b;
    alu_op    = gnt_id ? req1_op : req0_op;
  end

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .op       (alu_op),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      overflow_q   <= overflow_d;
      zero_q       <= zero_d;
    end
  end

  // Next state. A drain and an accept in the same cycle keep the slot FULL.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    result_d     = result_q;
    carry_d      = carry_q;
    overflow_d   = overflow_q;
    zero_d       = zero_q;
    if (accept) begin
      state_d      = FULL;
      last_grant_d = gnt_id;
      id_d         = gnt_id;
      result_d     = alu_result;
      carry_d      = alu_carry;
      overflow_d   = alu_overflow;
      zero_d       = alu_zero;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Outputs
  always_comb begin
    req0_ready   = slot_free && gnt_valid && !gnt_id && !rst;
    req1_ready   = slot_free && gnt_valid &&  gnt_id && !rst;
    rsp_valid    = (state_q == FULL);
    rsp_id       = id_q;
    rsp_result   = result_q;
    rsp_carry    = carry_q;
    rsp_overflow = overflow_q;
    rsp_zero     = zero_q;
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (accept && !gnt_id && (cnt0_q != '1)) cnt0_d = cnt0_q + 16'd1;
    if (accept &&  gnt_id && (cnt1_q != '1)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational `alu` instance between two independent requesters.
- Each requester uses a valid/ready request port.
- Round-robin arbitration picks one request per cycle and drives it through the ALU.
- The ALU outputs are captured in a single-entry response register, with a requester ID and valid/ready backpressure.
- Sits between the issue logic of two client blocks and the shared ALU datapath.

Parameters:
- WIDTH, 16, operand/result width; passed to the internal alu instance.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_op  input  4  requester 0 opcode (ALU encoding 0000-0111; others yield 0).
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_id  output  1  requester that issued the response (0/1).
- rsp_result  output  WIDTH  registered ALU RESULT.
- rsp_carry  output  1  registered ALU CARRY.
- rsp_overflow  output  1  registered ALU OVERFLOW.
- rsp_zero  output  1  registered ALU ZERO.

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow: 0.
  - rsp_zero: 1, consistent with result 0.
  - last_grant: 1, so requester 0 has priority first.
- Reset mid-operation discards any held response. req*_ready stays 0 while rst=1.
- Output state machine:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - slot_free = EMPTY or (FULL and rsp_ready).
- Grant, combinational:
  - Only one requester valid: it wins.
  - Both valid: the requester not equal to last_grant wins.
  - Neither valid: no grant.
- req_ready handshake:
  - reqN_ready = slot_free and grant==N.
  - The losing requester sees ready=0 and must hold its inputs stable until accepted.
- Grant datapath: winner's A/B/OP are muxed into the alu. On the clk edge, RESULT/CARRY/OVERFLOW/ZERO and id are registered.
- Transfer effects: rsp_valid=1 and last_grant updated to the winner.
- Latency: accept at edge N, response visible after edge N, held until the rsp_ready edge.
- Throughput: one op per cycle. A drain and a new accept in the same cycle go FULL→FULL with no bubble.
- FULL and rsp_ready=0: no accept; all response outputs held stable.
- FULL, rsp_ready=1, no requester valid: FULL→EMPTY. Data registers may hold stale values, but rsp_valid=0.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1…
- Arithmetic: identical to the shared alu.
  - ADD/SUB carry is bit WIDTH of the (WIDTH+1)-bit result; SUB carry = borrow.
  - Compare writes 1/0 in bit 0.
  - Undefined opcodes give result 0, zero=1.
- rsp_ready while EMPTY has no effect.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds output ports gnt_cnt0 and gnt_cnt1 (16 bits each).
  - Each counts accepted transfers for its requester and saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset → rsp_valid=0, rsp_zero=1, req0_ready=req1_ready=0 during rst.
- Single ADD: req0 A=16'hFFFF, B=16'h0001, op=0000, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_result=16'h0000, rsp_carry=1, rsp_zero=1.
- Contention: both valid every cycle after reset; req0 SUB 5-3, req1 XOR 16'h00F0^16'h0FF0 → ids 0,1,0,1…; results 16'h0002 (carry 0) and 16'h0F00.
- Backpressure: rsp_ready=0 for 3 cycles with req1 valid (op=0111, A=9, B=4) pending → rsp outputs frozen, req1_ready=0. Raise rsp_ready → req1 accepted the same cycle, and the next response is rsp_result=1, rsp_id=1.
- Reset mid-stream: assert rst while FULL and both valid → next cycle rsp_valid=0, and the first post-reset grant goes to req0.
- With ALU_ARB_STATS_EN: 5 req0 + 3 req1 accepts → gnt_cnt0=5, gnt_cnt1=3. With the counter forced near max → holds at 16'hFFFF.
